// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode and controller-state encodings.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_SUB   = 2'b00,
    OP_ADD   = 2'b01,
    OP_MUL   = 2'b10,
    OP_SCL35 = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Start/done request bus between the controller FSM (master) and the ALU (slave).
interface alu_seq_if #(
  parameter int WIDTH = 9
);
  logic             start;
  logic [1:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;

  modport master (
    output start, sel, a, b,
    input  ready, done, result, zero, carry
  );

  modport slave (
    input  start, sel, a, b,
    output ready, done, result, zero, carry
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative LSB-first shift-add multiplier: one partial product per cycle, WIDTH cycles per load.
module alu_mul_iter #(
  parameter int WIDTH = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic               last
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    addend;
  logic             busy;

  always_comb begin
    busy     = (cnt_q < CW'(WIDTH));
    addend   = mplier_q[0] ? mcand_q : '0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = W2'(a);
      mplier_d = b;
      cnt_d    = '0;
    end else if (busy) begin
      acc_d    = acc_q + addend;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
    end
  end

  // Counter parks at WIDTH when idle so last can never fire without a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= CW'(WIDTH);
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // prod includes the current cycle's partial product, so the final value is
  // available on the same edge that performs the last iteration.
  assign prod = acc_q + addend;
  assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: start/done handshake, latched operands, registered result and flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, carry_q;

  logic             accept;
  logic             write_en;
  logic             mul_last;
  logic [W2-1:0]    mul_prod;
  logic [W2-1:0]    wide_res;
  logic [WIDTH-1:0] trunc_res;
  logic             carry_calc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_EXEC;
      S_EXEC:  if (op_q != OP_MUL || mul_last) state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_EXEC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state_q != S_EXEC);
    bus.done  = (state_q == S_DONE);
    accept    = bus.start && (state_q != S_EXEC);
    write_en  = (state_q == S_EXEC) && (op_q != OP_MUL || mul_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= OP_SUB;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= op_e'(bus.sel);
      a_q  <= bus.a;
      b_q  <= bus.b;
    end
  end

  // The multiplier loads straight from the bus so its first iteration lines up
  // with the first EXEC cycle.
  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .a    (bus.a),
    .b    (bus.b),
    .prod (mul_prod),
    .last (mul_last)
  );

  always_comb begin
    wide_res   = '0;
    carry_calc = 1'b0;
    case (op_q)
      OP_ADD: begin
        wide_res   = W2'(a_q) + W2'(b_q);
        carry_calc = wide_res[WIDTH];
      end
      OP_SUB: begin
        wide_res   = W2'(a_q) - W2'(b_q);
        carry_calc = (a_q < b_q);
      end
      OP_MUL: begin
        wide_res   = mul_prod;
        carry_calc = |wide_res[W2-1:WIDTH];
      end
      OP_SCL35: begin
        wide_res   = (W2'(b_q) << 1) + W2'(b_q) + W2'(b_q >> 1);
        carry_calc = |wide_res[W2-1:WIDTH];
      end
      default: begin
        wide_res   = '0;
        carry_calc = 1'b0;
      end
    endcase
    trunc_res = wide_res[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else if (write_en) begin
      result_q <= trunc_res;
      zero_q   <= (trunc_res == '0);
      carry_q  <= carry_calc;
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.carry  = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=9: vector table plus handshake and reset sequences.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 9;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(
    .WIDTH(W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int sel;
    int a;
    int b;
    int res;
    int z;
    int c;
    int lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int sel, input int a, input int b, input int exp_res,
                        input int exp_z, input int exp_c, input int exp_lat, input string tag);
    int lat;
    bus.start = 1'b1;
    bus.sel   = 2'(sel);
    bus.a     = W'(a);
    bus.b     = W'(b);
    tick();
    bus.start = 1'b0;
    bus.sel   = 2'($urandom);
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    chk({tag, "_busy"}, int'(bus.ready), 0);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    $display("txn %s sel=%0d a=%0d b=%0d -> result=%0d zero=%0d carry=%0d latency=%0d",
             tag, sel, a, b, bus.result, bus.zero, bus.carry, lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, int'(bus.result), exp_res);
    chk({tag, "_zero"}, int'(bus.zero), exp_z);
    chk({tag, "_carry"}, int'(bus.carry), exp_c);
    tick();
  endtask

  initial begin
    int pulses;

    vecs[0]  = '{int'(OP_ADD),   200, 100, 300, 0, 0, 2};
    vecs[1]  = '{int'(OP_ADD),   400, 200,  88, 0, 1, 2};
    vecs[2]  = '{int'(OP_ADD),   511,   1,   0, 1, 1, 2};
    vecs[3]  = '{int'(OP_SUB),     5,   7, 510, 0, 1, 2};
    vecs[4]  = '{int'(OP_SUB),     7,   7,   0, 1, 0, 2};
    vecs[5]  = '{int'(OP_SUB),   300,  45, 255, 0, 0, 2};
    vecs[6]  = '{int'(OP_MUL),    23,  11, 253, 0, 0, 10};
    vecs[7]  = '{int'(OP_MUL),    30,  20,  88, 0, 1, 10};
    vecs[8]  = '{int'(OP_MUL),    77,   0,   0, 1, 0, 10};
    vecs[9]  = '{int'(OP_MUL),   511, 511,   1, 0, 1, 10};
    vecs[10] = '{int'(OP_SCL35), 123,  10,  35, 0, 0, 2};
    vecs[11] = '{int'(OP_SCL35),   0, 200, 188, 0, 1, 2};
    vecs[12] = '{int'(OP_SCL35), 511,   1,   3, 0, 0, 2};
    vecs[13] = '{int'(OP_SCL35),  42,   0,   0, 1, 0, 2};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sel   = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    rst = 1'b0;
    $display("txn reset: ready=%0d done=%0d result=%0d", bus.ready, bus.done, bus.result);
    chk("rst_ready", int'(bus.ready), 1);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_zero", int'(bus.zero), 0);
    chk("rst_carry", int'(bus.carry), 0);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].z, vecs[i].c,
             vecs[i].lat, $sformatf("vec%0d", i));
    end

    // start held through MUL EXEC must be ignored
    bus.start = 1'b1;
    bus.sel   = 2'(OP_MUL);
    bus.a     = 9'd23;
    bus.b     = 9'd11;
    tick();
    bus.sel = 2'(OP_ADD);
    bus.a   = 9'd1;
    bus.b   = 9'd1;
    chk("hold_ready", int'(bus.ready), 0);
    for (int k = 1; k <= 8; k++) tick();
    bus.start = 1'b0;
    tick();
    $display("txn hold_mul: done=%0d result=%0d", bus.done, bus.result);
    chk("hold_done", int'(bus.done), 1);
    chk("hold_res", int'(bus.result), 253);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    chk("hold_no_extra", pulses, 0);

    // back-to-back start in the DONE cycle
    bus.start = 1'b1;
    bus.sel   = 2'(OP_ADD);
    bus.a     = 9'd3;
    bus.b     = 9'd4;
    tick();
    bus.start = 1'b0;
    tick();
    chk("b2b_done1", int'(bus.done), 1);
    chk("b2b_res1", int'(bus.result), 7);
    bus.start = 1'b1;
    bus.a     = 9'd1;
    bus.b     = 9'd1;
    tick();
    bus.start = 1'b0;
    chk("b2b_busy", int'(bus.ready), 0);
    chk("b2b_gap", int'(bus.done), 0);
    tick();
    $display("txn b2b_add: done=%0d result=%0d", bus.done, bus.result);
    chk("b2b_done2", int'(bus.done), 1);
    chk("b2b_res2", int'(bus.result), 2);
    tick();

    // reset in the middle of a MUL
    bus.start = 1'b1;
    bus.sel   = 2'(OP_MUL);
    bus.a     = 9'd30;
    bus.b     = 9'd20;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("txn mid_rst: ready=%0d result=%0d zero=%0d carry=%0d",
             bus.ready, bus.result, bus.zero, bus.carry);
    chk("mrst_ready", int'(bus.ready), 1);
    chk("mrst_result", int'(bus.result), 0);
    chk("mrst_zero", int'(bus.zero), 0);
    chk("mrst_carry", int'(bus.carry), 0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done === 1'b1) pulses++;
      tick();
    end
    chk("mrst_no_done", pulses, 0);
    run_op(int'(OP_ADD), 1, 2, 3, 0, 0, 2, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
